seq_chunk_adder: RTL and testbench

Parametrised multi-cycle adder that computes `a + b + c` over a WIDTH-bit operand pair, one CHUNK-bit slice per clock, with a registered carry between slices. It generalises the fixed two-slice 8-bit ripple composition into a width- and chunk-configurable, handshaked datapath block. It is intended for wide arithmetic where a full-width carry chain would limit clock frequency.

---
 rtl/seq_chunk_adder.sv | 106 ++++++++++
 tb/tb_seq_chunk_adder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: a + b + c computed CHUNK bits per clock with a registered inter-slice carry.
// Define SEQ_CHUNK_ADDER_SUB_EN to add the `sub` input selecting a - b - c.
module seq_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out
);
    localparam int NCH = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $error("seq_chunk_adder: CHUNK must be >= 1");
        end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic [WIDTH:0]   r_out;

    logic [WIDTH-1:0] w_b_in;
    logic             w_c_in;
    logic [CHUNK-1:0] w_sa;
    logic [CHUNK-1:0] w_sb;
    logic [CHUNK:0]   w_sum;
    logic             w_last;
    logic             w_accept;

    // Subtraction is a + ~b + ~c, so the operand is inverted once at capture.
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub ? ~c : c;
`else
    assign w_b_in = b;
    assign w_c_in = c;
`endif

    assign w_sa     = r_a[int'(r_idx) * CHUNK +: CHUNK];
    assign w_sb     = r_b[int'(r_idx) * CHUNK +: CHUNK];
    assign w_sum    = {1'b0, w_sa} + {1'b0, w_sb} + {{CHUNK{1'b0}}, r_carry};
    assign w_last   = (r_idx == LAST);
    assign w_accept = in_valid && in_ready;
    assign out      = r_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = S_RUN;
            S_RUN:  if (w_last) w_next = S_DONE;
            S_DONE: if (out_ready) w_next = in_valid ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_out   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_c_in;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_out[int'(r_idx) * CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
            r_carry <= w_sum[CHUNK];
            if (w_last) r_out[WIDTH] <= w_sum[CHUNK];
            else        r_idx <= r_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three configurations (8/4, 16/4, 8/8) against an arithmetic model.
module tb_seq_chunk_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv   [3];
    logic        ordy [3];
    logic        cin  [3];
    logic [15:0] av   [3];
    logic [15:0] bv   [3];
    wire         ir   [3];
    wire         ov   [3];
    wire  [16:0] ou   [3];
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    logic        sb   [3];
`endif
    wire  [8:0]  o0;
    wire  [16:0] o1;
    wire  [8:0]  o2;
    assign ou[0] = {8'b0, o0};
    assign ou[1] = o1;
    assign ou[2] = {8'b0, o2};

    int n_tot = 0;
    int n_bad = 0;

    seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0][7:0]), .b(bv[0][7:0]), .c(cin[0]),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .sub(sb[0]),
`endif
        .out_valid(ov[0]), .out_ready(ordy[0]), .out(o0));

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1]), .b(bv[1]), .c(cin[1]),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .sub(sb[1]),
`endif
        .out_valid(ov[1]), .out_ready(ordy[1]), .out(o1));

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(av[2][7:0]), .b(bv[2][7:0]), .c(cin[2]),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .sub(sb[2]),
`endif
        .out_valid(ov[2]), .out_ready(ordy[2]), .out(o2));

    function automatic int wid(input int d);
        return (d == 1) ? 16 : 8;
    endfunction

    function automatic int nch(input int d);
        return (d == 0) ? 2 : (d == 1) ? 4 : 1;
    endfunction

    // a+b+c, or a-b-c offset by 2^W so the top bit reads as "no borrow"
    function automatic logic [16:0] model(input int w, input logic [15:0] aa, input logic [15:0] bb,
                                          input logic cc, input logic sbv);
        longint x;
        longint m;
        m = longint'(1) << (w + 1);
        if (sbv) x = longint'(aa) - longint'(bb) - longint'(cc) + (longint'(1) << w);
        else     x = longint'(aa) + longint'(bb) + longint'(cc);
        return 17'(x % m);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic txn(input int d, input logic [15:0] aa, input logic [15:0] bb,
                       input logic cc, input logic sbv, input int stall);
        logic [16:0] e;
        e = model(wid(d), aa, bb, cc, sbv);
        @(negedge clk);
        chk("idle_rdy", 32'(ir[d]), 32'd1);
        iv[d] = 1'b1; av[d] = aa; bv[d] = bb; cin[d] = cc; ordy[d] = 1'b0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        sb[d] = sbv;
`endif
        for (int j = 0; j <= nch(d); j++) begin
            @(negedge clk);
            if (j < nch(d)) begin
                chk("run_vld", 32'(ov[d]), 32'd0);
                chk("run_rdy", 32'(ir[d]), 32'd0);
                // junk offered during RUN must not be captured
                iv[d] = 1'b1; av[d] = 16'($urandom); bv[d] = 16'($urandom); cin[d] = 1'($urandom);
            end else begin
                chk("lat_vld", 32'(ov[d]), 32'd1);
                chk("sum", 32'(ou[d]), 32'(e));
                iv[d] = 1'b0;
            end
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("bp_vld", 32'(ov[d]), 32'd1);
            chk("bp_out", 32'(ou[d]), 32'(e));
            chk("bp_rdy", 32'(ir[d]), 32'd0);
        end
        ordy[d] = 1'b1;
        #1;
        chk("xfer_rdy", 32'(ir[d]), 32'd1);
        @(negedge clk);
        chk("post_vld", 32'(ov[d]), 32'd0);
        ordy[d] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; cin[d] = 1'b0; av[d] = '0; bv[d] = '0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
            sb[d] = 1'b0;
`endif
        end
        #12;
        for (int d = 0; d < 3; d++) begin
            chk("rst_vld", 32'(ov[d]), 32'd0);
            chk("rst_out", 32'(ou[d]), 32'd0);
            chk("rst_rdy", 32'(ir[d]), 32'd1);
        end
        @(negedge clk);
        rst = 1'b0;

        txn(0, 16'hFF, 16'h01, 1'b1, 1'b0, 0);
        txn(0, 16'h3C, 16'h0F, 1'b0, 1'b0, 5);
        txn(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        txn(2, 16'hFF, 16'hFF, 1'b1, 1'b0, 1);

        // back-to-back through DONE -> RUN
        @(negedge clk);
        chk("b2b_rdy0", 32'(ir[0]), 32'd1);
        iv[0] = 1'b1; av[0] = 16'h12; bv[0] = 16'h34; cin[0] = 1'b0; ordy[0] = 1'b1;
        @(negedge clk);
        av[0] = 16'h80; bv[0] = 16'h80; cin[0] = 1'b1;
        @(negedge clk);
        chk("b2b_vld_early", 32'(ov[0]), 32'd0);
        @(negedge clk);
        chk("b2b_vld1", 32'(ov[0]), 32'd1);
        chk("b2b_out1", 32'(ou[0]), 32'h046);
        chk("b2b_rdy1", 32'(ir[0]), 32'd1);
        @(negedge clk);
        chk("b2b_gap", 32'(ov[0]), 32'd0);
        iv[0] = 1'b0;
        @(negedge clk);
        chk("b2b_gap2", 32'(ov[0]), 32'd0);
        @(negedge clk);
        chk("b2b_vld2", 32'(ov[0]), 32'd1);
        chk("b2b_out2", 32'(ou[0]), 32'h101);
        @(negedge clk);
        chk("b2b_end", 32'(ov[0]), 32'd0);
        chk("b2b_idle", 32'(ir[0]), 32'd1);
        ordy[0] = 1'b0;

        // async reset after slice 0
        @(negedge clk);
        iv[0] = 1'b1; av[0] = 16'hFF; bv[0] = 16'hFF; cin[0] = 1'b0; ordy[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_vld", 32'(ov[0]), 32'd0);
        chk("arst_out", 32'(ou[0]), 32'd0);
        chk("arst_rdy", 32'(ir[0]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("arst_quiet", 32'(ov[0]), 32'd0);
        end
        ordy[0] = 1'b0;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
        txn(0, 16'h10, 16'h01, 1'b0, 1'b1, 0);
        txn(0, 16'h00, 16'h01, 1'b0, 1'b1, 0);
        txn(0, 16'h05, 16'h05, 1'b1, 1'b1, 2);
`endif

        for (int n = 0; n < 60; n++) begin
            int d;
            logic [15:0] m, ra, rb;
            logic sbv;
            d  = int'($urandom_range(2, 0));
            m  = (d == 1) ? 16'hFFFF : 16'h00FF;
            ra = 16'($urandom) & m;
            rb = 16'($urandom) & m;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
            sbv = 1'($urandom);
`else
            sbv = 1'b0;
`endif
            txn(d, ra, rb, 1'($urandom), sbv, int'($urandom_range(3, 0)));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
